// File: rtl/bomb_catch_scorer_if.sv
// Bomb/player position bus and scorer result signals shared by the scorer and its neighbours.
// The master drives positions and keycode; the slave (scorer) drives the score, lives and event strobes.
interface bomb_catch_scorer_if;
  logic [9:0] bombX;
  logic [9:0] bombY;
  logic [9:0] playerX;
  logic [9:0] playerY;
  logic [7:0] keycode;
  logic [3:0] curPoints;
  logic [1:0] lives;
  logic       catch_pulse;
  logic       miss_pulse;
  logic       game_over;

  modport master (
    output bombX, bombY, playerX, playerY, keycode,
    input  curPoints, lives, catch_pulse, miss_pulse, game_over
  );

  modport slave (
    input  bombX, bombY, playerX, playerY, keycode,
    output curPoints, lives, catch_pulse, miss_pulse, game_over
  );
endinterface

// File: rtl/bomb_catch_scorer.sv
// Per-frame catch/miss scorer: one event per armed drop, score saturates, lives count down to game over.
// All outputs registered, events visible one frame_clk edge after their cause; no backpressure.
module bomb_catch_scorer #(
  parameter int BOMB_SIZE     = 4,
  parameter int PLAYER_HALF_W = 16,
  parameter int PLAYER_HALF_H = 8,
  parameter int Y_ARM         = 240,
  parameter int Y_FLOOR       = 479,
  parameter int MAX_POINTS    = 10,
  parameter int START_LIVES   = 3,
  parameter logic [7:0] RESTART_KEY = 8'h28
) (
  input logic                  frame_clk,
  input logic                  Reset,
  bomb_catch_scorer_if.slave   bus
);

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_ARMED = 2'd1,
    S_OVER  = 2'd2
  } state_t;

  localparam logic [9:0]  Y_ARM_C   = 10'(Y_ARM);
  localparam logic [9:0]  Y_FLOOR_C = 10'(Y_FLOOR);
  localparam logic [10:0] LIM_X     = 11'(BOMB_SIZE + PLAYER_HALF_W);
  localparam logic [10:0] LIM_Y     = 11'(BOMB_SIZE + PLAYER_HALF_H);
  localparam logic [3:0]  MAX_PTS_C = 4'(MAX_POINTS);
  localparam logic [1:0]  LIVES_C   = 2'(START_LIVES);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_points, w_points_nxt;
  logic [1:0] r_lives, w_lives_nxt;
  logic       r_catch, w_catch_nxt;
  logic       r_miss, w_miss_nxt;
  logic       r_over;

  logic [9:0] w_dx, w_dy;
  logic       w_overlap, w_floor;

  // Unsigned distances: subtract the smaller coordinate from the larger so nothing wraps.
  assign w_dx = (bus.bombX >= bus.playerX) ? (bus.bombX - bus.playerX) : (bus.playerX - bus.bombX);
  assign w_dy = (bus.bombY >= bus.playerY) ? (bus.bombY - bus.playerY) : (bus.playerY - bus.bombY);
  assign w_overlap = ({1'b0, w_dx} <= LIM_X) && ({1'b0, w_dy} <= LIM_Y);
  assign w_floor   = (bus.bombY >= Y_FLOOR_C);

  always_comb begin
    w_state_nxt  = r_state;
    w_points_nxt = r_points;
    w_lives_nxt  = r_lives;
    w_catch_nxt  = 1'b0;
    w_miss_nxt   = 1'b0;
    case (r_state)
      S_WAIT: begin
        if (bus.bombY == Y_ARM_C) w_state_nxt = S_ARMED;
      end
      S_ARMED: begin
        // Catch is checked first so a bomb overlapping the player at the floor never costs a life.
        if (w_overlap) begin
          if (r_points < MAX_PTS_C) w_points_nxt = r_points + 4'd1;
          w_catch_nxt = 1'b1;
          w_state_nxt = S_WAIT;
        end else if (w_floor) begin
          w_miss_nxt = 1'b1;
          if (r_lives != 2'd0) w_lives_nxt = r_lives - 2'd1;
          w_state_nxt = (r_lives <= 2'd1) ? S_OVER : S_WAIT;
        end
      end
      S_OVER: begin
        if (bus.keycode == RESTART_KEY) begin
          w_points_nxt = 4'd0;
          w_lives_nxt  = LIVES_C;
          w_state_nxt  = S_WAIT;
        end
      end
      default: w_state_nxt = S_WAIT;
    endcase
  end

  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      r_state  <= S_WAIT;
      r_points <= 4'd0;
      r_lives  <= LIVES_C;
      r_catch  <= 1'b0;
      r_miss   <= 1'b0;
      r_over   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_points <= w_points_nxt;
      r_lives  <= w_lives_nxt;
      r_catch  <= w_catch_nxt;
      r_miss   <= w_miss_nxt;
      r_over   <= (w_state_nxt == S_OVER);
    end
  end

  assign bus.curPoints   = r_points;
  assign bus.lives       = r_lives;
  assign bus.catch_pulse = r_catch;
  assign bus.miss_pulse  = r_miss;
  assign bus.game_over   = r_over;

endmodule

// File: tb/tb_bomb_catch_scorer.sv
// Directed scenarios plus randomized frames, checked every cycle against a rule-level model of the game.
module tb_bomb_catch_scorer;
  logic frame_clk = 1'b0;
  logic Reset;
  bomb_catch_scorer_if bus ();

  bomb_catch_scorer dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus)
  );

  always #5 frame_clk = ~frame_clk;

  int checks = 0;
  int errors = 0;
  int n_catch = 0;
  int n_miss  = 0;

  // Model of the game rules: armed flag, score, lives, over flag, last-edge events.
  int m_armed  = 0;
  int m_over   = 0;
  int m_points = 0;
  int m_lives  = 3;
  int m_catch  = 0;
  int m_miss   = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge frame_clk or negedge Reset) begin
    int dx, dy, np, nl, na, no, nc, nm;
    if (!Reset) begin
      m_armed <= 0; m_over <= 0; m_points <= 0; m_lives <= 3; m_catch <= 0; m_miss <= 0;
    end else begin
      dx = int'(bus.bombX) - int'(bus.playerX);
      dy = int'(bus.bombY) - int'(bus.playerY);
      if (dx < 0) dx = -dx;
      if (dy < 0) dy = -dy;
      np = m_points; nl = m_lives; na = m_armed; no = m_over; nc = 0; nm = 0;
      if (m_over != 0) begin
        if (bus.keycode == 8'h28) begin np = 0; nl = 3; no = 0; end
      end else if (m_armed == 0) begin
        if (bus.bombY == 10'd240) na = 1;
      end else if (dx <= 20 && dy <= 12) begin
        np = (m_points + 1 > 10) ? 10 : m_points + 1;
        nc = 1; na = 0;
      end else if (bus.bombY >= 10'd479) begin
        nl = (m_lives > 0) ? m_lives - 1 : 0;
        nm = 1; na = 0;
        if (nl == 0) no = 1;
      end
      m_points <= np; m_lives <= nl; m_armed <= na; m_over <= no; m_catch <= nc; m_miss <= nm;
    end
  end

  always @(negedge frame_clk) begin
    check("curPoints", int'(bus.curPoints), m_points);
    check("lives", int'(bus.lives), m_lives);
    check("catch_pulse", int'(bus.catch_pulse), m_catch);
    check("miss_pulse", int'(bus.miss_pulse), m_miss);
    check("game_over", int'(bus.game_over), m_over);
    check("pulse_exclusive", int'(bus.catch_pulse & bus.miss_pulse), 0);
    if (bus.catch_pulse) n_catch++;
    if (bus.miss_pulse) n_miss++;
  end

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic set_bomb(input int x, input int y);
    bus.bombX = 10'(x);
    bus.bombY = 10'(y);
  endtask

  task automatic set_player(input int x, input int y);
    bus.playerX = 10'(x);
    bus.playerY = 10'(y);
  endtask

  // One drop: arm at the spawn row, then one frame at (x,y), then a neutral frame.
  task automatic drop(input int x, input int y);
    set_bomb(x, 240); tick();
    set_bomb(x, y);   tick();
    set_bomb(x, 0);   tick();
  endtask

  initial begin
    int c0, m0, x, y, px, py, r;
    Reset = 1'b0;
    set_bomb(0, 0);
    set_player(370, 300);
    bus.keycode = 8'h00;
    repeat (2) tick();
    check("reset_points", int'(bus.curPoints), 0);
    check("reset_lives", int'(bus.lives), 3);
    check("reset_over", int'(bus.game_over), 0);
    Reset = 1'b1;
    tick();

    // Catch as the bomb falls onto the player; lingering overlap scores once.
    c0 = n_catch;
    set_bomb(370, 240); tick();
    for (int yy = 250; yy <= 300; yy += 10) begin set_bomb(370, yy); tick(); end
    repeat (4) begin set_bomb(370, 305); tick(); end
    check("catch_count", n_catch - c0, 1);
    check("catch_points", int'(bus.curPoints), 1);
    check("catch_lives", int'(bus.lives), 3);

    // Miss: bomb falls past a player far to the left.
    set_player(100, 300);
    m0 = n_miss;
    set_bomb(370, 240); tick();
    for (int yy = 250; yy <= 470; yy += 10) begin set_bomb(370, yy); tick(); end
    set_bomb(370, 479); tick();
    set_bomb(370, 0); tick();
    check("miss_count", n_miss - m0, 1);
    check("miss_lives", int'(bus.lives), 2);
    check("miss_points", int'(bus.curPoints), 1);
    check("miss_not_over", int'(bus.game_over), 0);

    // Two more misses end the game; later drops change nothing until restart.
    drop(370, 479);
    drop(370, 479);
    check("over_lives", int'(bus.lives), 0);
    check("over_flag", int'(bus.game_over), 1);
    set_player(370, 300);
    c0 = n_catch;
    drop(370, 300);
    drop(370, 479);
    check("over_no_catch", n_catch - c0, 0);
    check("over_points_held", int'(bus.curPoints), 1);
    bus.keycode = 8'h28; tick();
    bus.keycode = 8'h00;
    check("restart_points", int'(bus.curPoints), 0);
    check("restart_lives", int'(bus.lives), 3);
    check("restart_over", int'(bus.game_over), 0);
    tick();

    // Saturation at ten points; the eleventh catch still pulses.
    c0 = n_catch;
    repeat (10) drop(370, 300);
    check("sat_points_10", int'(bus.curPoints), 10);
    drop(370, 300);
    check("sat_points_hold", int'(bus.curPoints), 10);
    check("sat_catch_count", n_catch - c0, 11);

    // Overlap at the floor row: catch wins.
    set_player(370, 475);
    c0 = n_catch; m0 = n_miss;
    drop(370, 479);
    check("floor_catch", n_catch - c0, 1);
    check("floor_no_miss", n_miss - m0, 0);
    check("floor_lives", int'(bus.lives), 3);

    // Horizontal boundary in both directions.
    set_player(100, 300);
    c0 = n_catch;
    drop(120, 300);
    drop(80, 300);
    check("dx20_catch", n_catch - c0, 2);
    c0 = n_catch; m0 = n_miss;
    set_bomb(121, 240); tick();
    set_bomb(121, 300); tick();
    set_bomb(121, 479); tick();
    set_bomb(121, 0); tick();
    check("dx21_no_catch", n_catch - c0, 0);
    check("dx21_miss", n_miss - m0, 1);
    check("dx21_lives", int'(bus.lives), 2);

    // Asynchronous reset mid-drop discards the armed drop.
    #2 Reset = 1'b0;
    #1 Reset = 1'b1;
    tick();
    set_player(370, 300);
    repeat (5) drop(370, 300);
    check("pre_reset_points", int'(bus.curPoints), 5);
    set_bomb(370, 240); tick();
    set_bomb(370, 250); tick();
    #1 Reset = 1'b0;
    #1;
    check("async_points", int'(bus.curPoints), 0);
    check("async_lives", int'(bus.lives), 3);
    check("async_over", int'(bus.game_over), 0);
    tick();
    Reset = 1'b1;
    c0 = n_catch;
    repeat (5) begin set_bomb(370, 300); tick(); end
    check("post_reset_no_event", n_catch - c0, 0);
    set_bomb(370, 240); tick();
    set_bomb(370, 300); tick();
    tick();
    check("post_reset_rearm", n_catch - c0, 1);
    check("post_reset_points", int'(bus.curPoints), 1);

    // Randomized frames against the model.
    px = 300; py = 300;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        px = $urandom_range(30, 600);
        py = $urandom_range(30, 470);
      end
      set_player(px, py);
      r = $urandom_range(0, 9);
      x = px + $urandom_range(0, 60) - 30;
      if (x < 0) x = 0;
      if (r <= 2)      y = 240;
      else if (r == 3) y = 479 + $urandom_range(0, 3);
      else if (r <= 6) y = py + $urandom_range(0, 30) - 15;
      else             y = $urandom_range(0, 479);
      if (y < 0) y = 0;
      set_bomb(x, y);
      bus.keycode = ($urandom_range(0, 7) == 0) ? 8'h28 : 8'($urandom_range(0, 255));
      tick();
    end
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
